// File: rtl/battle_pkg.sv
// Shared definitions for the battle control FSM and its datapath.
// Holds trainer encodings, HP width, LFSR taps and small arithmetic helpers.
package battle_pkg;

    localparam int HP_W = 8;
    typedef logic [HP_W-1:0] hp_t;

    localparam logic PLAYER = 1'b0;
    localparam logic AI     = 1'b1;

    // Feedback taps 8,6,5,4 map onto bits 7,5,4,3 of the register
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic hp_t sat_sub(input hp_t a, input hp_t b);
        return (a > b) ? hp_t'(a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/battle_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used for critical hits and catch rolls.
module battle_lfsr8
    import battle_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] q
);

    logic [7:0] r_q;

    // Shift register: reload the seed on reset, otherwise step every cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= SEED;
        end else begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/battle_datapath.sv
// Battle datapath: HP, potion and catch state driven by one-cycle FSM strobes,
// with combinational damage, dead flags and catch result fed back to the FSM.
module battle_datapath
    import battle_pkg::*;
#(
    parameter logic [7:0] P_MAX_HP  = 8'd100,
    parameter logic [7:0] P_ATK     = 8'd20,
    parameter logic [7:0] P_DEF     = 8'd10,
    parameter logic [7:0] AI_ATK    = 8'd18,
    parameter logic [7:0] AI_DEF    = 8'd12,
    parameter logic [7:0] HEAL_AMT  = 8'd30,
    parameter logic [1:0] POTIONS   = 2'd3,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter bit         CRIT_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_ai_hp,
    input  logic [7:0] ai_hp_in,
    input  logic       active_trainer,
    input  logic       target,
    input  logic       apply_ai_damage,
    input  logic       apply_p_damage,
    input  logic       p_heal,
    input  logic       catch,
    output logic [7:0] p_hp,
    output logic [7:0] ai_hp,
    output logic [1:0] potions_left,
    output logic [7:0] last_dmg,
    output logic       ai_dead,
    output logic       p_dead,
    output logic       catch_success,
    output logic       caught
);

    logic [7:0] w_lfsr;

    hp_t        r_p_hp, r_ai_hp, r_last_dmg;
    logic [1:0] r_potions;
    logic       r_loaded, r_caught;

    hp_t        w_p_hp_nxt, w_ai_hp_nxt, w_last_dmg_nxt;
    logic [1:0] w_potions_nxt;
    logic       w_loaded_nxt, w_caught_nxt;

    hp_t        w_atk, w_half_def, w_base, w_dmg, w_thresh, w_p_healed, w_p_pre;
    logic [8:0] w_dbl, w_heal_sum;
    logic       w_crit, w_frozen, w_active, w_heal_ok, w_catch_ok;

    battle_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (w_lfsr)
    );

    // Damage for the current attacker/defender pair, doubled on a critical roll
    always_comb begin
        w_atk      = (active_trainer == AI) ? AI_ATK : P_ATK;
        w_half_def = ((target == AI) ? AI_DEF : P_DEF) >> 1;
        w_base     = (w_atk > w_half_def) ? hp_t'(w_atk - w_half_def) : 8'd1;
        w_crit     = (CRIT_EN == 1'b1) && (w_lfsr[2:0] == 3'd0);
        w_dbl      = {1'b0, w_base} << 1;
        if (w_crit) begin
            w_dmg = (w_dbl > 9'd255) ? 8'hFF : w_dbl[7:0];
        end else begin
            w_dmg = w_base;
        end
    end

    assign ai_dead  = r_loaded && (r_ai_hp == 8'd0);
    assign p_dead   = r_loaded && (r_p_hp == 8'd0);
    assign w_frozen = ai_dead || p_dead || r_caught;
    assign w_active = r_loaded && !w_frozen;

    assign w_thresh      = (8'd255 - r_ai_hp) >> 1;
    assign w_catch_ok    = catch && w_active && (w_lfsr < w_thresh);
    assign catch_success = w_catch_ok;

    // Heal is applied before any simultaneous player damage
    always_comb begin
        w_heal_ok  = p_heal && (r_potions != 2'd0);
        w_heal_sum = {1'b0, r_p_hp} + {1'b0, HEAL_AMT};
        w_p_healed = (w_heal_sum > {1'b0, P_MAX_HP}) ? P_MAX_HP : w_heal_sum[7:0];
        w_p_pre    = w_heal_ok ? w_p_healed : r_p_hp;
    end

    // Next-state selection: load wins, strobes act only in a live battle
    always_comb begin
        w_p_hp_nxt     = r_p_hp;
        w_ai_hp_nxt    = r_ai_hp;
        w_last_dmg_nxt = r_last_dmg;
        w_potions_nxt  = r_potions;
        w_loaded_nxt   = r_loaded;
        w_caught_nxt   = r_caught;
        if (load_ai_hp) begin
            w_ai_hp_nxt    = ai_hp_in;
            w_p_hp_nxt     = P_MAX_HP;
            w_potions_nxt  = POTIONS;
            w_loaded_nxt   = 1'b1;
            w_caught_nxt   = 1'b0;
            w_last_dmg_nxt = 8'd0;
        end else if (w_active) begin
            if (apply_ai_damage) begin
                w_ai_hp_nxt    = sat_sub(r_ai_hp, w_dmg);
                w_last_dmg_nxt = w_dmg;
            end else begin
                w_ai_hp_nxt = r_ai_hp;
            end
            if (apply_p_damage) begin
                w_p_hp_nxt     = sat_sub(w_p_pre, w_dmg);
                w_last_dmg_nxt = w_dmg;
            end else begin
                w_p_hp_nxt = w_p_pre;
            end
            if (w_heal_ok) begin
                w_potions_nxt = r_potions - 2'd1;
            end else begin
                w_potions_nxt = r_potions;
            end
            if (w_catch_ok) begin
                w_caught_nxt = 1'b1;
            end else begin
                w_caught_nxt = r_caught;
            end
        end else begin
            w_loaded_nxt = r_loaded;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_p_hp     <= P_MAX_HP;
            r_ai_hp    <= 8'd0;
            r_potions  <= POTIONS;
            r_last_dmg <= 8'd0;
            r_loaded   <= 1'b0;
            r_caught   <= 1'b0;
        end else begin
            r_p_hp     <= w_p_hp_nxt;
            r_ai_hp    <= w_ai_hp_nxt;
            r_potions  <= w_potions_nxt;
            r_last_dmg <= w_last_dmg_nxt;
            r_loaded   <= w_loaded_nxt;
            r_caught   <= w_caught_nxt;
        end
    end

    assign p_hp         = r_p_hp;
    assign ai_hp        = r_ai_hp;
    assign potions_left = r_potions;
    assign last_dmg     = r_last_dmg;
    assign caught       = r_caught;

endmodule

// File: tb/tb_battle_datapath.sv
// Scoreboard bench for battle_datapath: one instance without and one with critical hits.
module tb_battle_datapath;

    localparam int S_P = 0, S_AI = 1, S_POT = 2, S_LAST = 3, S_AID = 4, S_PD = 5, S_CS = 6, S_CAUGHT = 7;

    typedef struct {
        int    due;
        int    dut;
        int    sig;
        int    exp;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   neg_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    logic       clk = 1'b0;
    logic       reset_n, load_ai_hp, active_trainer, target;
    logic       apply_ai_damage, apply_p_damage, p_heal, catch;
    logic [7:0] ai_hp_in;
    logic [7:0] m_lfsr;

    logic [7:0] p_hp0, ai_hp0, last0, p_hp1, ai_hp1, last1;
    logic [1:0] pot0, pot1;
    logic       aid0, pd0, cs0, cg0, aid1, pd1, cs1, cg1;

    battle_datapath #(.CRIT_EN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp), .ai_hp_in(ai_hp_in),
        .active_trainer(active_trainer), .target(target), .apply_ai_damage(apply_ai_damage),
        .apply_p_damage(apply_p_damage), .p_heal(p_heal), .catch(catch),
        .p_hp(p_hp0), .ai_hp(ai_hp0), .potions_left(pot0), .last_dmg(last0),
        .ai_dead(aid0), .p_dead(pd0), .catch_success(cs0), .caught(cg0)
    );

    battle_datapath #(.CRIT_EN(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load_ai_hp(load_ai_hp), .ai_hp_in(ai_hp_in),
        .active_trainer(active_trainer), .target(target), .apply_ai_damage(apply_ai_damage),
        .apply_p_damage(apply_p_damage), .p_heal(p_heal), .catch(catch),
        .p_hp(p_hp1), .ai_hp(ai_hp1), .potions_left(pot1), .last_dmg(last1),
        .ai_dead(aid1), .p_dead(pd1), .catch_success(cs1), .caught(cg1)
    );

    always #5 clk = ~clk;

    // Reference LFSR (taps 8,6,5,4, seed A5)
    always @(posedge clk) begin
        m_lfsr <= (!reset_n) ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic int get(input int d, input int s);
        case (s)
            S_P:     return (d == 0) ? int'(p_hp0) : int'(p_hp1);
            S_AI:    return (d == 0) ? int'(ai_hp0) : int'(ai_hp1);
            S_POT:   return (d == 0) ? int'(pot0) : int'(pot1);
            S_LAST:  return (d == 0) ? int'(last0) : int'(last1);
            S_AID:   return (d == 0) ? int'(aid0) : int'(aid1);
            S_PD:    return (d == 0) ? int'(pd0) : int'(pd1);
            S_CS:    return (d == 0) ? int'(cs0) : int'(cs1);
            default: return (d == 0) ? int'(cg0) : int'(cg1);
        endcase
    endfunction

    // Monitor: at each falling edge compare every entry that has come due
    initial begin
        forever begin
            @(negedge clk);
            neg_cnt = neg_cnt + 1;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].due == neg_cnt) begin
                    checks = checks + 1;
                    if (get(sbq[i].dut, sbq[i].sig) !== sbq[i].exp) begin
                        errors = errors + 1;
                        $display("FAIL %s dut%0d: got %0d expected %0d", sbq[i].name,
                                 sbq[i].dut, get(sbq[i].dut, sbq[i].sig), sbq[i].exp);
                    end
                    sbq.delete(i);
                end
            end
        end
    end

    // lat 1: combinational/current value; lat 2: result of a strobe issued this cycle
    task automatic ex(input int d, input int s, input int v, input int lat, input string nm);
        exp_t e;
        e.due = neg_cnt + lat; e.dut = d; e.sig = s; e.exp = v; e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        load_ai_hp = 1'b0; apply_ai_damage = 1'b0; apply_p_damage = 1'b0;
        p_heal = 1'b0; catch = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] v);
        ai_hp_in = v; load_ai_hp = 1'b1;
        ex(0, S_AI, v, 2, "load_ai");
        ex(0, S_P, 100, 2, "load_p");
        ex(0, S_POT, 3, 2, "load_pot");
        step();
    endtask

    int ai_exp [4] = '{36, 22, 8, 0};
    int p_hit  [5] = '{87, 74, 61, 48, 35};
    int p_heal_v [4] = '{65, 95, 100, 100};
    int pot_v  [4] = '{2, 1, 0, 0};
    int m_ai1;
    int dmg1;
    bit found;

    initial begin
        reset_n = 1'b0; load_ai_hp = 1'b0; ai_hp_in = 8'd0; active_trainer = 1'b0; target = 1'b1;
        apply_ai_damage = 1'b0; apply_p_damage = 1'b0; p_heal = 1'b0; catch = 1'b0;
        do_reset();

        ex(0, S_P, 100, 1, "rst_p"); ex(0, S_AI, 0, 1, "rst_ai"); ex(0, S_POT, 3, 1, "rst_pot");
        ex(0, S_LAST, 0, 1, "rst_last"); ex(0, S_AID, 0, 1, "rst_aid"); ex(0, S_PD, 0, 1, "rst_pd");
        ex(0, S_CAUGHT, 0, 1, "rst_caught");
        step();

        // Strobes before the first load are ignored
        apply_ai_damage = 1'b1; apply_p_damage = 1'b1; p_heal = 1'b1;
        ex(0, S_P, 100, 2, "preload_p"); ex(0, S_POT, 3, 2, "preload_pot");
        ex(0, S_LAST, 0, 2, "preload_last");
        step();

        // Load has priority over a simultaneous strike
        apply_ai_damage = 1'b1;
        ex(0, S_AID, 0, 2, "t1_aid"); ex(0, S_PD, 0, 2, "t1_pd"); ex(0, S_LAST, 0, 2, "t1_last");
        load(8'd50);

        active_trainer = 1'b0; target = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply_ai_damage = 1'b1;
            ex(0, S_AI, ai_exp[k], 2, "t2_ai"); ex(0, S_LAST, 14, 2, "t2_last");
            step();
        end
        ex(0, S_AID, 1, 1, "t2_aid");
        apply_ai_damage = 1'b1; apply_p_damage = 1'b1; p_heal = 1'b1;
        ex(0, S_AI, 0, 2, "t2_frozen_ai"); ex(0, S_P, 100, 2, "t2_frozen_p");
        ex(0, S_POT, 3, 2, "t2_frozen_pot");
        step();

        load(8'd250);
        active_trainer = 1'b1; target = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_p_damage = 1'b1;
            ex(0, S_P, p_hit[k], 2, "t3_hit"); ex(0, S_LAST, 13, 2, "t3_last");
            step();
        end
        for (int k = 0; k < 4; k++) begin
            p_heal = 1'b1;
            ex(0, S_P, p_heal_v[k], 2, "t3_heal"); ex(0, S_POT, pot_v[k], 2, "t3_pot");
            step();
        end

        load(8'd250);
        apply_p_damage = 1'b1;
        ex(0, S_P, 87, 2, "t4_hit");
        step();
        apply_p_damage = 1'b1; p_heal = 1'b1;
        ex(0, S_P, 87, 2, "t4_heal_dmg"); ex(0, S_POT, 2, 2, "t4_pot");
        step();
        for (int k = 0; k < 7; k++) begin
            apply_p_damage = 1'b1;
            step();
        end
        ex(0, S_P, 0, 1, "t4_p_zero"); ex(0, S_PD, 1, 1, "t4_pd");
        active_trainer = 1'b0; target = 1'b1; apply_ai_damage = 1'b1;
        ex(0, S_AI, 250, 2, "t4_frozen_ai");
        step();

        // Critical hits on dut1 follow the reference LFSR
        do_reset();
        load(8'd250);
        m_ai1 = 250;
        active_trainer = 1'b0; target = 1'b1;
        for (int k = 0; k < 6; k++) begin
            dmg1 = (m_lfsr[2:0] == 3'd0) ? 28 : 14;
            m_ai1 = m_ai1 - dmg1;
            apply_ai_damage = 1'b1;
            ex(1, S_AI, m_ai1, 2, "t5_crit_ai"); ex(1, S_LAST, dmg1, 2, "t5_crit_last");
            ex(0, S_AI, 250 - 14 * (k + 1), 2, "t5_nocrit_ai");
            step();
        end
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (m_lfsr[2:0] == 3'd0) found = 1'b1;
            else step();
        end
        if (!found) begin
            checks = checks + 1; errors = errors + 1;
            $display("FAIL t5_wait: got no crit cycle expected one within 300");
        end else begin
            m_ai1 = m_ai1 - 28;
            apply_ai_damage = 1'b1;
            ex(1, S_LAST, 28, 2, "t5_crit28"); ex(1, S_AI, m_ai1, 2, "t5_crit28_ai");
            ex(0, S_LAST, 14, 2, "t5_nocrit14");
            step();
        end

        // Catch: fainted AI cannot be caught; ai_hp 1 gives threshold 127
        load(8'd0);
        ex(0, S_AID, 1, 1, "t6_aid");
        catch = 1'b1;
        ex(0, S_CS, 0, 1, "t6_dead_cs"); ex(0, S_CAUGHT, 0, 2, "t6_dead_caught");
        step();
        load(8'd1);
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            found = (m_lfsr < 8'd127);
            catch = 1'b1;
            ex(0, S_CS, int'(found), 1, "t6_cs");
            ex(0, S_CAUGHT, int'(found), 2, "t6_caught");
            step();
        end
        if (!found) begin
            checks = checks + 1; errors = errors + 1;
            $display("FAIL t6_wait: got no success expected one within 64");
        end
        apply_ai_damage = 1'b1; catch = 1'b1;
        ex(0, S_CS, 0, 1, "t6_after_cs"); ex(0, S_AI, 1, 2, "t6_after_ai");
        step();

        // Reset mid-battle clears everything
        do_reset();
        ex(0, S_CAUGHT, 0, 1, "rst2_caught"); ex(0, S_AI, 0, 1, "rst2_ai");
        ex(0, S_P, 100, 1, "rst2_p"); ex(0, S_AID, 0, 1, "rst2_aid");
        step();

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            errors = errors + sbq.size(); checks = checks + sbq.size();
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
